// File: rtl/icap_multiboot_ctrl.sv
// Spartan-6 MultiBoot controller: streams the ICAP reboot sequence that loads
// GENERAL_1/GENERAL_2 with the selected slot's SPI address, then issues IPROG.
module icap_multiboot_ctrl #(
    parameter int          NUM_SLOTS     = 4,
    parameter int          SLOT_W        = 2,
    parameter logic [31:0] BASE_ADDR     = 32'h0305_4000,
    parameter logic [31:0] SLOT_STRIDE   = 32'h0005_4000,
    parameter logic [31:0] LOADER_ADDR   = 32'h0300_0000,
    parameter int          CLK_DIV       = 4,
    parameter int          STARTUP_TICKS = 65536
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic [SLOT_W-1:0] slot,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              icap_clk,
    output logic              icap_ce,
    output logic              icap_wr,
    output logic [15:0]       icap_din
);
    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(STARTUP_TICKS + 1);
    localparam logic [3:0] LAST_IDX = 4'd13;

    typedef enum logic [1:0] {ST_STARTUP, ST_IDLE, ST_SEND} state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         idx_q, idx_d;
    logic [31:0]        addr_q, addr_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               clk_q, clk_d;
    logic               ce_q, ce_d;
    logic               wr_q, wr_d;
    logic [15:0]        din_q, din_d;
    logic               tick;
    logic [31:0]        slot_ext;

    function automatic logic [15:0] byte_rev(input logic [15:0] w);
        logic [15:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i]     = w[7-i];
            r[8+i]   = w[15-i];
        end
        return r;
    endfunction

    // Dummy, sync, GENERAL_1, GENERAL_2, CMD=IPROG, then NOOP padding.
    function automatic logic [15:0] seq_word(input logic [3:0] i, input logic [31:0] a);
        case (i)
            4'd0:    return 16'hFFFF;
            4'd1:    return 16'hAA99;
            4'd2:    return 16'h5566;
            4'd3:    return 16'h3261;
            4'd4:    return a[15:0];
            4'd5:    return 16'h3281;
            4'd6:    return a[31:16];
            4'd7:    return 16'h30A1;
            4'd8:    return 16'h000E;
            default: return 16'h2000;
        endcase
    endfunction

    assign tick     = (div_q == '0);
    assign slot_ext = {{(32-SLOT_W){1'b0}}, slot};

    always_comb begin
        state_d = state_q;
        div_d   = (div_q == DIV_W'(CLK_DIV - 1)) ? '0 : div_q + 1'b1;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        clk_d   = (div_d >= DIV_W'(CLK_DIV / 2));
        ce_d    = ce_q;
        wr_d    = wr_q;
        din_d   = din_q;
        case (state_q)
            ST_STARTUP: begin
                if (tick) begin
                    if (cnt_q == CNT_W'(STARTUP_TICKS - 1)) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (req) begin
                    if (slot_ext < 32'(NUM_SLOTS)) begin
                        addr_d = BASE_ADDR + slot_ext * SLOT_STRIDE;
                        err_d  = 1'b0;
                    end else begin
                        addr_d = LOADER_ADDR;
                        err_d  = 1'b1;
                    end
                    busy_d  = 1'b1;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                // idx 13 means word 12 has now been held for a full ICAP period.
                if (tick) begin
                    if (idx_q == LAST_IDX) begin
                        ce_d    = 1'b1;
                        wr_d    = 1'b1;
                        din_d   = 16'hFFFF;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        ce_d  = 1'b0;
                        wr_d  = 1'b0;
                        din_d = byte_rev(seq_word(idx_q, addr_q));
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_STARTUP;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_STARTUP;
            div_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            clk_q   <= 1'b0;
            ce_q    <= 1'b1;
            wr_q    <= 1'b1;
            din_q   <= 16'hFFFF;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            clk_q   <= clk_d;
            ce_q    <= ce_d;
            wr_q    <= wr_d;
            din_q   <= din_d;
        end
    end

    always_ff @(posedge clock) begin
        addr_q <= addr_d;
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign icap_clk = clk_q;
    assign icap_ce  = ce_q;
    assign icap_wr  = wr_q;
    assign icap_din = din_q;

endmodule
